// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared definitions for the Morse playback keyer: FSM state encoding and the
// element timing constants, expressed in Morse units.
// -----------------------------------------------------------------------------
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DOT_UNITS  = 1;
  localparam int DASH_UNITS = 3;
  localparam int GAP_UNITS  = 1;
  localparam int MAX_LEN    = 5;

endpackage

// File: rtl/morse_keyer_unit_timer.sv
// -----------------------------------------------------------------------------
// unit_timer
// Clear/enable cycle counter measuring one element (mark or gap) in Morse units.
// Counts 0..(units*UNIT_CYCLES - 1) while enabled, flags the terminal count
// and wraps to zero on it, so back-to-back elements need no extra clear.
//
// Ports:
//   clk       in  clock
//   rst       in  synchronous active-low reset
//   i_clear   in  force count to zero
//   i_enable  in  advance the count
//   i_units   in  element duration in units (1 or 3)
//   o_expire  out high on the final cycle of the element
// -----------------------------------------------------------------------------
module unit_timer #(
  parameter int UNIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       i_enable,
  input  logic [1:0] i_units,
  output logic       o_expire
);
  import morse_pkg::*;

  // Wide enough for the longest element; 3*UNIT_CYCLES-1 always fits.
  localparam int TW = $clog2(DASH_UNITS * UNIT_CYCLES);
  localparam logic [TW-1:0] LAST_SHORT = TW'(UNIT_CYCLES - 1);
  localparam logic [TW-1:0] LAST_LONG  = TW'(DASH_UNITS * UNIT_CYCLES - 1);

  logic [TW-1:0] r_count;
  logic [TW-1:0] w_last;

  assign w_last   = (i_units == 2'(DASH_UNITS)) ? LAST_LONG : LAST_SHORT;
  assign o_expire = i_enable && (r_count == w_last);

  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values of the others; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= o_expire ? '0 : r_count + TW'(1);
    end
  end

endmodule

// File: rtl/morse_keyer.sv
// -----------------------------------------------------------------------------
// morse_keyer
// Plays one Morse character on an active-low key line: dot = 1 unit low,
// dash = 3 units low, 1 unit high between elements, then a one-cycle done.
//
// Ports:
//   clk      in  clock, posedge
//   rst      in  synchronous active-low reset (wins over start)
//   start    in  one-cycle request, honoured only when idle
//   code     in  [MAX_LEN-1:0] element pattern, 1 = dash, bit 0 played first
//   len      in  [2:0] element count, clipped to MAX_LEN
//   key_out  out active-low key (0 = mark)
//   busy     out high whenever not idle
//   done     out one-cycle pulse after the last mark
// -----------------------------------------------------------------------------
module morse_keyer #(
  parameter int UNIT_CYCLES = 4,
  parameter int MAX_LEN     = morse_pkg::MAX_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MAX_LEN-1:0] code,
  input  logic [2:0]         len,
  output logic               key_out,
  output logic               busy,
  output logic               done
);
  import morse_pkg::*;

  localparam logic [2:0] MAX_LEN_3 = 3'(MAX_LEN);

  state_t             r_state;
  state_t             w_next;
  logic [MAX_LEN-1:0] r_shift;
  logic [2:0]         r_remain;
  logic [2:0]         w_eff_len;
  logic [1:0]         w_units;
  logic               w_expire;
  logic               w_timing;

  assign w_eff_len = (len > MAX_LEN_3) ? MAX_LEN_3 : len;
  assign w_timing  = (r_state == ST_MARK) || (r_state == ST_SPACE);

  // NOTE: every signal driven in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    w_units = 2'(GAP_UNITS);
    if (r_state == ST_MARK) begin
      w_units = r_shift[0] ? 2'(DASH_UNITS) : 2'(DOT_UNITS);
    end
  end

  // Timer is held at zero outside MARK/SPACE, so the first mark starts at 0.
  unit_timer #(
    .UNIT_CYCLES (UNIT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (!w_timing),
    .i_enable (w_timing),
    .i_units  (w_units),
    .o_expire (w_expire)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = (w_eff_len == 3'd0) ? ST_DONE : ST_MARK;
        end
      end
      ST_MARK: begin
        // r_remain still counts the element now ending; >1 means more follow.
        if (w_expire) begin
          w_next = (r_remain > 3'd1) ? ST_SPACE : ST_DONE;
        end
      end
      ST_SPACE: begin
        if (w_expire) begin
          w_next = ST_MARK;
        end
      end
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_remain <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_IDLE) && start) begin
        r_shift  <= code;
        r_remain <= w_eff_len;
      end else if ((r_state == ST_MARK) && w_expire) begin
        r_shift <= r_shift >> 1;
        if (r_remain != 3'd0) begin
          r_remain <= r_remain - 3'd1;
        end
      end
    end
  end

  // Moore outputs decoded straight from the state register.
  assign key_out = (r_state != ST_MARK);
  assign busy    = (r_state == ST_MARK) || (r_state == ST_SPACE) || (r_state == ST_DONE);
  assign done    = (r_state == ST_DONE);

endmodule

// File: tb/tb_morse_keyer.sv
// -----------------------------------------------------------------------------
// tb_morse_keyer
// Self-checking bench for morse_keyer with UNIT_CYCLES = 4. Expected key/busy/
// done waveforms come from a timeline model built from the element rules
// (dot/dash/gap lengths) as a queue of key levels.
// -----------------------------------------------------------------------------
module tb_morse_keyer;

  localparam int U = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] code;
  logic [2:0] len;
  logic       key_out;
  logic       busy;
  logic       done;

  int n_checks;
  int n_fail;

  morse_keyer #(
    .UNIT_CYCLES (U),
    .MAX_LEN     (5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .code    (code),
    .len     (len),
    .key_out (key_out),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] code;
    logic [2:0] len;
    int         exp_done;
    int         exp_low;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plays one character and compares every cycle against the timeline model.
  // Ends in the IDLE cycle after done without advancing, so a following call
  // presents its start in that IDLE cycle. rp_a/rp_b re-pulse start mid-run.
  task automatic run_char(input string tag, input logic [4:0] c, input logic [2:0] l,
                          input int rp_a, input int rp_b,
                          output int obs_done, output int obs_low);
    bit m_key[$];
    int eff;
    int d;
    int n;
    logic e_key, e_busy, e_done;
    eff = (l > 3'd5) ? 5 : int'(l);
    for (int i = 0; i < eff; i++) begin
      d = c[i] ? 3 * U : U;
      repeat (d) m_key.push_back(1'b0);
      if (i < eff - 1) repeat (U) m_key.push_back(1'b1);
    end
    n = m_key.size();

    code  = c;
    len   = l;
    start = 1'b1;
    tick();
    start = 1'b0;
    code  = 5'($urandom);
    len   = 3'($urandom);

    obs_done = -1;
    obs_low  = 0;
    for (int cyc = 1; cyc <= n + 2; cyc++) begin
      if (cyc <= n) begin
        e_key = m_key[cyc-1]; e_busy = 1'b1; e_done = 1'b0;
      end else if (cyc == n + 1) begin
        e_key = 1'b1; e_busy = 1'b1; e_done = 1'b1;
      end else begin
        e_key = 1'b1; e_busy = 1'b0; e_done = 1'b0;
      end
      check($sformatf("%s key c%0d", tag, cyc), 32'(key_out), 32'(e_key));
      check($sformatf("%s busy c%0d", tag, cyc), 32'(busy), 32'(e_busy));
      check($sformatf("%s done c%0d", tag, cyc), 32'(done), 32'(e_done));
      if (done && obs_done < 0) obs_done = cyc;
      if (!key_out) obs_low++;
      start = (cyc == rp_a) || (cyc == rp_b);
      if (cyc <= n + 1) tick();
    end
    start = 1'b0;
  endtask

  initial begin
    int od, ol, ndone, nlow;
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{"E",        5'b00000, 3'd1,  5,  4};
    vecs[1] = '{"A",        5'b00010, 3'd2, 21, 16};
    vecs[2] = '{"len0",     5'b10110, 3'd0,  1,  0};
    vecs[3] = '{"len7",     5'b11111, 3'd7, 77, 60};
    vecs[4] = '{"B",        5'b00001, 3'd4, 37, 24};
    vecs[5] = '{"len6clip", 5'b10101, 3'd6, 61, 44};

    rst = 1'b0; start = 1'b0; code = '0; len = '0;
    repeat (3) tick();
    check("reset key_out", 32'(key_out), 32'd1);
    check("reset busy",    32'(busy),    32'd0);
    check("reset done",    32'(done),    32'd0);
    rst = 1'b1;
    tick();

    // Table-driven characters.
    foreach (vecs[k]) begin
      run_char(vecs[k].name, vecs[k].code, vecs[k].len, -1, -1, od, ol);
      check({vecs[k].name, " done cycle"}, 32'(od), 32'(vecs[k].exp_done));
      check({vecs[k].name, " low cycles"}, 32'(ol), 32'(vecs[k].exp_low));
      tick();
    end

    // Start re-pulsed mid-character is ignored.
    run_char("A-repulse", 5'b00010, 3'd2, 3, 10, od, ol);
    check("A-repulse done cycle", 32'(od), 32'd21);
    ndone = 0;
    repeat (6) begin
      tick();
      if (done) ndone++;
    end
    check("A-repulse extra done", 32'(ndone), 32'd0);

    // Back-to-back: second start lands in the IDLE cycle after 'E'.
    run_char("E1", 5'b00000, 3'd1, -1, -1, od, ol);
    run_char("E2", 5'b00000, 3'd1, -1, -1, od, ol);
    check("E2 done cycle", 32'(od), 32'd5);
    tick();

    // Reset in the middle of the dash of 'A'.
    code = 5'b00010; len = 3'd2; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    check("abort key before rst c12", 32'(key_out), 32'd0);
    rst = 1'b0;
    tick();
    check("abort key c13",  32'(key_out), 32'd1);
    check("abort busy c13", 32'(busy),    32'd0);
    check("abort done c13", 32'(done),    32'd0);
    rst = 1'b1;
    ndone = 0; nlow = 0;
    repeat (30) begin
      tick();
      if (done) ndone++;
      if (!key_out) nlow++;
    end
    check("abort no done", 32'(ndone), 32'd0);
    check("abort no mark", 32'(nlow),  32'd0);

    // Reset coincident with start: stays idle.
    rst = 1'b0; start = 1'b1; code = 5'b00001; len = 3'd1;
    tick();
    rst = 1'b1; start = 1'b0;
    check("rst+start busy",  32'(busy),    32'd0);
    check("rst+start key",   32'(key_out), 32'd1);
    tick();
    check("rst+start busy2", 32'(busy),    32'd0);
    check("rst+start done2", 32'(done),    32'd0);

    // Randomized characters with random idle gaps.
    for (int r = 0; r < 40; r++) begin
      run_char($sformatf("rnd%0d", r), 5'($urandom), 3'($urandom), -1, -1, od, ol);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
